mux_sel_arbiter_4: RTL and testbench



---
 rtl/mux_sel_arbiter_4_pkg.sv | 20 ++
 rtl/mux_sel_arbiter_4_if.sv | 22 ++
 rtl/mux_sel_arbiter_4_rr_pick_4.sv | 26 ++
 rtl/mux_sel_arbiter_4.sv | 95 +++++++++
 tb/tb_mux_sel_arbiter_4.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_sel_arbiter_4_pkg.sv
// Shared types and constants for the 4-source mux select arbiter.
package mux_sel_pkg;

  localparam int unsigned N_SRC = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Registered output payload driven onto the mux select bus
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [N_SRC-1:0] gnt;
    logic             valid;
  } arb_out_t;

endpackage

// File: rtl/mux_sel_arbiter_4_if.sv
// Request/grant bus between the four sources, the arbiter and the downstream 4:1 mux.
interface mux_sel_arbiter_4_if;
  import mux_sel_pkg::*;

  logic [N_SRC-1:0] req;
  logic             done;
  logic             S0;
  logic             S1;
  logic [N_SRC-1:0] gnt;
  logic             gnt_valid;

  modport master (
    input  req, done,
    output S0, S1, gnt, gnt_valid
  );

  modport slave (
    output req, done,
    input  S0, S1, gnt, gnt_valid
  );

endinterface

// File: rtl/mux_sel_arbiter_4_rr_pick_4.sv
// Combinational round-robin search: first set req bit at ptr, ptr+1, ... mod 4.
module rr_pick_4
  import mux_sel_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found_c,
  output logic [SEL_W-1:0] idx_c
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found_c = 1'b0;
    idx_c   = ptr;
    cand    = ptr;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found_c && req[cand]) begin
        found_c = 1'b1;
        idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter_4.sv
// Round-robin arbiter driving the S1/S0 selects of a 4:1 mux, with a one-cycle guard gap.
// Optional forced release after MAX_DWELL cycles when MUX_SEL_TIMEOUT_EN is defined.
module mux_sel_arbiter_4
  import mux_sel_pkg::*;
#(
  parameter int unsigned MAX_DWELL = 8,
  parameter int unsigned DWELL_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_sel_arbiter_4_if.master  bus
);

`ifdef MUX_SEL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  arb_state_e       state_q, state_d;
  arb_out_t         out_q, out_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic             pick_found_c;
  logic [SEL_W-1:0] pick_idx_c;
  logic             timeout_c;
  logic             release_c;

  rr_pick_4 u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .found_c (pick_found_c),
    .idx_c   (pick_idx_c)
  );

  assign timeout_c = TIMEOUT_EN && (dwell_q == DWELL_W'(MAX_DWELL - 1));
  assign release_c = bus.done || !bus.req[out_q.sel] || timeout_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      ptr_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
    end
  end

  // Next state; S1/S0 hold their last value whenever no grant is active
  always_comb begin
    state_d       = state_q;
    out_d         = out_q;
    out_d.gnt     = '0;
    out_d.valid   = 1'b0;
    ptr_d         = ptr_q;
    dwell_d       = dwell_q;

    case (state_q)
      GRANT: begin
        dwell_d = (&dwell_q) ? dwell_q : dwell_q + DWELL_W'(1);
        if (release_c) begin
          state_d = GAP;
          ptr_d   = out_q.sel + SEL_W'(1);
        end else begin
          out_d.gnt   = out_q.gnt;
          out_d.valid = 1'b1;
        end
      end
      // The gap cycle itself shows no grant; arbitrating here keeps it to one invalid cycle
      IDLE, GAP: begin
        state_d = IDLE;
        if (pick_found_c) begin
          state_d     = GRANT;
          out_d.sel   = pick_idx_c;
          out_d.gnt   = N_SRC'(1) << pick_idx_c;
          out_d.valid = 1'b1;
          dwell_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.S1        = out_q.sel[1];
  assign bus.S0        = out_q.sel[0];
  assign bus.gnt       = out_q.gnt;
  assign bus.gnt_valid = out_q.valid;

endmodule

// File: tb/tb_mux_sel_arbiter_4.sv
// Self-checking bench for mux_sel_arbiter_4: directed scenarios plus randomized traffic vs a behavioural model.
module tb_mux_sel_arbiter_4;

  localparam int unsigned MAX_DWELL = 8;
`ifdef MUX_SEL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_sel_arbiter_4_if bus ();

  mux_sel_arbiter_4 #(.MAX_DWELL(MAX_DWELL), .DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: who holds the grant, for how long, and where the search starts next
  bit m_busy;
  int m_w, m_ptr, m_held, m_sel;

  function automatic void model_reset();
    m_busy = 1'b0; m_w = 0; m_ptr = 0; m_held = 0; m_sel = 0;
  endfunction

  function automatic void model_step(logic [3:0] r, logic d);
    int s;
    if (m_busy) begin
      if (d || !r[m_w] || (TO_EN && m_held >= MAX_DWELL)) begin
        m_busy = 1'b0;
        m_ptr  = (m_w + 1) % 4;
      end else begin
        m_held++;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        s = (m_ptr + k) % 4;
        if (!m_busy && r[s]) begin
          m_busy = 1'b1; m_w = s; m_sel = s; m_held = 1;
        end
      end
    end
  endfunction

  function automatic logic [3:0] model_gnt();
    return m_busy ? 4'(1 << m_w) : 4'b0000;
  endfunction

  task automatic drive(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(bus.req, bus.done);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.S1, bus.S0, bus.gnt, bus.gnt_valid} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got S=%b%b gnt=%b v=%b, need S=00 gnt=0000 v=0",
                 i, bus.S1, bus.S0, bus.gnt, bus.gnt_valid);
      end
    end
    model_reset();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0001 || bus.gnt_valid !== 1'b1 || model_gnt() !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release: got gnt=%b v=%b, need gnt=0001 v=1", bus.gnt, bus.gnt_valid);
    end
  endtask

  task automatic test_single();
    apply_reset();
    drive(4'b0100, 1'b0);
    tick();
    n_cmp++;
    if ({bus.S1, bus.S0} !== 2'b10 || bus.gnt !== 4'b0100 || bus.gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got S=%b%b gnt=%b v=%b, need S=10 gnt=0100 v=1",
               bus.S1, bus.S0, bus.gnt, bus.gnt_valid);
    end
    drive(4'b0100, 1'b1);
    tick();
    n_cmp++;
    if ({bus.S1, bus.S0} !== 2'b10 || bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gap: got S=%b%b gnt=%b v=%b, need S=10 gnt=0000 v=0",
               bus.S1, bus.S0, bus.gnt, bus.gnt_valid);
    end
    drive(4'b0000, 1'b1);
    tick();
    n_cmp++;
    if ({bus.S1, bus.S0} !== 2'b10 || bus.gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle_done: got S=%b%b v=%b, need S=10 v=0", bus.S1, bus.S0, bus.gnt_valid);
    end
    drive(4'b0000, 1'b0);
  endtask

  task automatic test_fairness();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    drive(4'b1111, 1'b0);
    for (int g = 0; g < 5; g++) begin
      tick();
      n_cmp++;
      if (bus.gnt !== seq[g] || bus.gnt_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL fair_grant%0d: got gnt=%b v=%b, need gnt=%b v=1", g, bus.gnt, bus.gnt_valid, seq[g]);
      end
      drive(4'b1111, 1'b1);
      tick();
      n_cmp++;
      if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fair_gap%0d: got gnt=%b v=%b, need gnt=0000 v=0", g, bus.gnt, bus.gnt_valid);
      end
      drive(4'b1111, 1'b0);
    end
    drive(4'b0000, 1'b0);
  endtask

  task automatic test_drop_and_done();
    apply_reset();
    drive(4'b0010, 1'b0);
    tick();
    drive(4'b0001, 1'b1);
    tick();
    n_cmp++;
    if (bus.gnt_valid !== 1'b0 || {bus.S1, bus.S0} !== 2'b01) begin
      n_fail++;
      $display("FAIL drop_done_release: got S=%b%b v=%b, need S=01 v=0", bus.S1, bus.S0, bus.gnt_valid);
    end
    drive(4'b0011, 1'b0);
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0001 || bus.gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_done_next: got gnt=%b v=%b, need gnt=0001 v=1", bus.gnt, bus.gnt_valid);
    end
    drive(4'b0000, 1'b0);
  endtask

  task automatic test_timeout();
    int held;
    logic [3:0] hist [60];
    apply_reset();
    drive(4'b1001, 1'b0);
    for (int c = 0; c < 60; c++) begin
      tick();
      hist[c] = bus.gnt_valid ? bus.gnt : 4'b0000;
    end
    held = 0;
    while (held < 60 && hist[held] === 4'b0001) held++;
    n_cmp++;
    if (TO_EN) begin
      if (held != MAX_DWELL || hist[MAX_DWELL] !== 4'b0000 || hist[MAX_DWELL+1] !== 4'b1000) begin
        n_fail++;
        $display("FAIL timeout: got held=%0d then %b,%b, need held=%0d then 0000,1000",
                 held, hist[held], hist[held+1], MAX_DWELL);
      end
    end else begin
      if (held != 60) begin
        n_fail++;
        $display("FAIL no_timeout: got grant held %0d cycles, need 60", held);
      end
    end
    drive(4'b0000, 1'b0);
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(4'b0100, 1'b0);
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL async_pre: got gnt=%b, need 0100", bus.gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.S1, bus.S0, bus.gnt, bus.gnt_valid} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_clear: got S=%b%b gnt=%b v=%b, need all zero",
               bus.S1, bus.S0, bus.gnt, bus.gnt_valid);
    end
    drive(4'b0000, 1'b0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      bus.done = ($urandom_range(0, 4) == 0);
      tick();
      n_cmp++;
      if ({bus.S1, bus.S0} !== 2'(m_sel) || bus.gnt !== model_gnt() || bus.gnt_valid !== m_busy) begin
        n_fail++;
        $display("FAIL random cyc%0d: got S=%b%b gnt=%b v=%b, need S=%0d gnt=%b v=%b",
                 c, bus.S1, bus.S0, bus.gnt, bus.gnt_valid, m_sel, model_gnt(), m_busy);
      end
    end
    drive(4'b0000, 1'b0);
  endtask

  initial begin
    drive(4'b0000, 1'b0);
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_drop_and_done();
    test_timeout();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
